// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and constants for the MIPS fetch path
//
// Purpose: state encoding for the fetch sequencer, reset/step/link constants,
// and the branch-offset helper used by branch_resolve.
// Ports: none (package).

package mips_fetch_pkg;

  typedef enum logic [0:0] {
    S_BOOT  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] LINK_OFFSET      = 32'd8;

  // Sign-extended word offset of a conditional branch, already in bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - combinational branch condition, target and link address
//
// Purpose: evaluates the decode-stage branch condition and computes the
// redirect target and link address for the instruction in decode.
// Ports:
//   jump, lt, gt, eq, src   control vector from the branch decoder
//   rs_val, rt_val          forwarded operands (compared as signed)
//   dec_pc                  PC of the decode instruction
//   imm, target             branch offset / J-format index
//   cond                    comparison result
//   pc4                     dec_pc + 4 (delay-slot address)
//   target_addr             redirect address (jump or branch form)
//   link_addr               dec_pc + 8

module branch_resolve
  import mips_fetch_pkg::*;
(
  input  logic        jump,
  input  logic        lt,
  input  logic        gt,
  input  logic        eq,
  input  logic        src,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] dec_pc,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        cond,
  output logic [31:0] pc4,
  output logic [31:0] target_addr,
  output logic [31:0] link_addr
);

  logic        [31:0] rhs;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;

  assign pc4       = dec_pc + PC_STEP;
  assign link_addr = dec_pc + LINK_OFFSET;

  // Without src the comparison is against zero (BLTZ/BGEZ family).
  assign rhs = src ? rt_val : 32'd0;
  assign a_s = rs_val;
  assign b_s = rhs;

  assign cond = (lt & (a_s < b_s)) | (gt & (a_s > b_s)) | (eq & (rs_val == rhs));

  always_comb begin
    target_addr = pc4 + branch_offset(imm);
    if (jump) begin
      target_addr = src ? rs_val : {pc4[31:28], target, 2'b00};
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC controller with one-entry IF register and delay-slot redirect
//
// Purpose: owns the fetch PC, issues instruction-memory requests, holds the
// IF register feeding decode, and redirects fetch after exactly one delay slot.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   imem_req/addr/ack/rdata       instruction-memory request handshake
//   if_valid/if_instr/if_pc       IF register towards decode
//   stall                         decode not accepting
//   dec_valid, dec_pc             decode-stage instruction
//   jump..link, rs_val, rt_val,
//   imm, target                   branch decoder outputs and operands
//   br_taken                      redirect resolved this cycle
//   link_we, link_addr            link write for AL/JAL/JALR forms

module pc_sequencer
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        stall,
  input  logic        dec_valid,
  input  logic [31:0] dec_pc,
  input  logic        jump,
  input  logic        branch,
  input  logic        lt,
  input  logic        gt,
  input  logic        eq,
  input  logic        src,
  input  logic        link,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        br_taken,
  output logic        link_we,
  output logic [31:0] link_addr
);

  fetch_state_e state;
  fetch_state_e next_state;

  logic [31:0] fpc;
  logic        pend_valid;
  logic [31:0] pend_target;

  logic        cond;
  logic [31:0] pc4;
  logic [31:0] tgt;
  logic        res;
  logic        take;
  logic        kill;
  logic        pend_set;
  logic        transfer;
  logic        consume;

  branch_resolve u_resolve (
    .jump        (jump),
    .lt          (lt),
    .gt          (gt),
    .eq          (eq),
    .src         (src),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .dec_pc      (dec_pc),
    .imm         (imm),
    .target      (target),
    .cond        (cond),
    .pc4         (pc4),
    .target_addr (tgt),
    .link_addr   (link_addr)
  );

  assign res  = dec_valid & ~stall;
  assign take = res & ~reset & (jump | (branch & cond));

  // fpc != pc4 means the delay slot is already fetched, so the sequential
  // fetch in flight is wrong-path and is dropped this cycle.
  assign kill     = take & (fpc != pc4);
  assign pend_set = take & ~kill;

  assign imem_addr = fpc;
  assign br_taken  = take;
  assign link_we   = res & link & ~reset;

  always_comb begin
    next_state = S_FETCH;
    imem_req   = 1'b0;
    if (state == S_FETCH) begin
      imem_req = ~reset & (~if_valid | ~stall) & ~kill;
    end
  end

  assign transfer = imem_req & imem_ack;
  assign consume  = if_valid & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_BOOT;
      fpc         <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= 32'd0;
      if_pc       <= 32'd0;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
    end else begin
      state <= next_state;

      if (kill) begin
        fpc        <= tgt;
        pend_valid <= 1'b0;
      end else if (transfer) begin
        // A redirect resolving while its delay slot transfers goes straight
        // to the target instead of being parked in the pend register.
        if (pend_set) begin
          fpc <= tgt;
        end else if (pend_valid) begin
          fpc <= pend_target;
        end else begin
          fpc <= fpc + PC_STEP;
        end
        pend_valid <= 1'b0;
      end else if (pend_set) begin
        pend_valid  <= 1'b1;
        pend_target <= tgt;
      end

      if (transfer) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= fpc;
      end else if (consume) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer

module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        stall;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic        jump, branch, lt, gt, eq, src, link;
  logic [31:0] rs_val, rt_val;
  logic [15:0] imm;
  logic [25:0] target;
  logic        br_taken;
  logic        link_we;
  logic [31:0] link_addr;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .stall(stall), .dec_valid(dec_valid),
    .dec_pc(dec_pc), .jump(jump), .branch(branch), .lt(lt), .gt(gt), .eq(eq),
    .src(src), .link(link), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
    .target(target), .br_taken(br_taken), .link_we(link_we), .link_addr(link_addr)
  );

  always #5 clk = ~clk;

  task automatic idle();
    reset = 1'b0; imem_ack = 1'b1; stall = 1'b0; dec_valid = 1'b0; dec_pc = 32'd0;
    jump = 1'b0; branch = 1'b0; lt = 1'b0; gt = 1'b0; eq = 1'b0; src = 1'b0; link = 1'b0;
    rs_val = 32'd0; rt_val = 32'd0; imm = 16'd0; target = 26'd0;
  endtask

  // One-cycle JR from an unrelated decode PC: the delay slot is never pc4,
  // so fetch jumps straight to addr.
  task automatic redirect(input logic [31:0] addr);
    @(negedge clk);
    idle();
    dec_valid = 1'b1; jump = 1'b1; src = 1'b1; rs_val = addr; dec_pc = 32'h0000_0000;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; imem_rdata = 32'h1111_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %b exp 0", if_valid); end
      checks++; if (if_instr !== 32'd0 || if_pc !== 32'd0) begin errors++; $display("FAIL reset_if_regs got %h/%h exp 0/0", if_instr, if_pc); end
      checks++; if (br_taken !== 1'b0 || link_we !== 1'b0) begin errors++; $display("FAIL reset_br_link got %b/%b exp 0/0", br_taken, link_we); end
      checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, RST_PC); end
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", imem_req); end
    @(negedge clk); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin errors++; $display("FAIL first_req got %b@%h exp 1@%h", imem_req, imem_addr, RST_PC); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL first_if_valid got %b exp 0", if_valid); end
    @(negedge clk); imem_rdata = 32'h2222_0000; #1;
    checks++; if (imem_addr !== 32'hBFC0_0004) begin errors++; $display("FAIL seq_addr1 got %h exp bfc00004", imem_addr); end
    checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC || if_instr !== 32'h1111_0000) begin errors++; $display("FAIL first_if got %b %h %h exp 1 %h 11110000", if_valid, if_pc, if_instr, RST_PC); end
    @(negedge clk); #1;
    checks++; if (imem_addr !== 32'hBFC0_0008) begin errors++; $display("FAIL seq_addr2 got %h exp bfc00008", imem_addr); end
    checks++; if (if_pc !== 32'hBFC0_0004 || if_instr !== 32'h2222_0000) begin errors++; $display("FAIL second_if got %h %h exp bfc00004 22220000", if_pc, if_instr); end
  endtask

  task automatic test_beq_taken();
    redirect(32'h100);
    @(negedge clk); idle();
    @(negedge clk); idle();
    @(negedge clk); idle();
    dec_valid = 1'b1; branch = 1'b1; eq = 1'b1; src = 1'b1;
    rs_val = 32'd5; rt_val = 32'd5; imm = 16'h0010; dec_pc = 32'h100; #1;
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL beq_taken got %b exp 1", br_taken); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL beq_kill_req got %b exp 0", imem_req); end
    checks++; if (if_pc !== 32'h104) begin errors++; $display("FAIL beq_slot_in_if got %h exp 104", if_pc); end
    @(negedge clk); idle(); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h144) begin errors++; $display("FAIL beq_target_req got %b@%h exp 1@144", imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL beq_if_flushed got %b exp 0", if_valid); end
  endtask

  task automatic test_bne_not_taken();
    @(negedge clk); idle();
    dec_valid = 1'b1; branch = 1'b1; lt = 1'b1; gt = 1'b1; src = 1'b1;
    rs_val = 32'd7; rt_val = 32'd7; dec_pc = 32'h144; #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL bne_taken got %b exp 0", br_taken); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h148) begin errors++; $display("FAIL bne_seq_req got %b@%h exp 1@148", imem_req, imem_addr); end
    @(negedge clk); idle(); #1;
    checks++; if (imem_addr !== 32'h14C || if_pc !== 32'h148) begin errors++; $display("FAIL bne_continue got %h/%h exp 14c/148", imem_addr, if_pc); end
  endtask

  task automatic test_jalr_pending();
    redirect(32'h200);
    @(negedge clk); idle();
    @(negedge clk); idle(); imem_ack = 1'b0;
    dec_valid = 1'b1; jump = 1'b1; src = 1'b1; link = 1'b1; rs_val = 32'h8000; dec_pc = 32'h200; #1;
    checks++; if (link_we !== 1'b1 || link_addr !== 32'h208) begin errors++; $display("FAIL jalr_link got %b %h exp 1 208", link_we, link_addr); end
    checks++; if (br_taken !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h204) begin errors++; $display("FAIL jalr_resolve got %b %b@%h exp 1 1@204", br_taken, imem_req, imem_addr); end
    @(negedge clk); idle(); imem_ack = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin errors++; $display("FAIL jalr_slot_wait got %b@%h exp 1@204", imem_req, imem_addr); end
    @(negedge clk); idle(); imem_rdata = 32'h0000_0204; #1;
    checks++; if (imem_addr !== 32'h204) begin errors++; $display("FAIL jalr_slot_xfer got %h exp 204", imem_addr); end
    @(negedge clk); idle(); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000) begin errors++; $display("FAIL jalr_target got %b@%h exp 1@8000", imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h204) begin errors++; $display("FAIL jalr_slot_if got %b %h exp 1 204", if_valid, if_pc); end
  endtask

  task automatic test_bltzal();
    @(negedge clk); idle();
    dec_valid = 1'b1; branch = 1'b1; lt = 1'b1; link = 1'b1; src = 1'b0;
    rs_val = 32'd3; rt_val = 32'd16; dec_pc = 32'h1000; #1;
    checks++; if (link_we !== 1'b1 || link_addr !== 32'h1008) begin errors++; $display("FAIL bltzal_link got %b %h exp 1 1008", link_we, link_addr); end
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL bltzal_nt got %b exp 0", br_taken); end
    @(negedge clk); rs_val = 32'hFFFF_FFFD; #1;
    checks++; if (br_taken !== 1'b1 || link_we !== 1'b1) begin errors++; $display("FAIL bltzal_neg got %b %b exp 1 1", br_taken, link_we); end
  endtask

  task automatic test_stall_reset();
    redirect(32'h300);
    @(negedge clk); idle(); imem_rdata = 32'hCAFE_0300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle(); stall = 1'b1; imem_rdata = $urandom; #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got %b exp 0", imem_req); end
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h300 || if_instr !== 32'hCAFE_0300) begin errors++; $display("FAIL stall_hold got %b %h %h exp 1 300 cafe0300", if_valid, if_pc, if_instr); end
    end
    @(negedge clk); idle(); imem_ack = 1'b0;
    dec_valid = 1'b1; jump = 1'b1; target = 26'h100; dec_pc = 32'h300; #1;
    checks++; if (br_taken !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h304) begin errors++; $display("FAIL pend_setup got %b %b@%h exp 1 1@304", br_taken, imem_req, imem_addr); end
    @(negedge clk); idle(); reset = 1'b1; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_cycle_req got %b exp 0", imem_req); end
    @(negedge clk); idle(); #1;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL reboot got %b %b exp 0 0", imem_req, if_valid); end
    @(negedge clk); idle(); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin errors++; $display("FAIL reboot_req got %b@%h exp 1@%h", imem_req, imem_addr, RST_PC); end
    @(negedge clk); idle(); #1;
    checks++; if (imem_addr !== 32'hBFC0_0004) begin errors++; $display("FAIL pend_lost got %h exp bfc00004", imem_addr); end
  endtask

  // Reference: an in-order fetch stream with one delay slot after every
  // taken control transfer.
  task automatic test_random();
    logic        m_boot = 1'b1, m_ifv = 1'b0, m_redir = 1'b0;
    logic [31:0] m_fpc = RST_PC, m_ifi = 0, m_ifp = 0, m_redir_addr = 0, m_dpc = 0;
    logic [31:0] pc4, dest;
    logic        e_take, e_req, slot_fetched, fetched, consumed;
    int          sa, sb, off;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      reset = (i == 0) || ($urandom_range(0, 199) == 0);
      imem_ack = ($urandom_range(0, 3) != 0); stall = ($urandom_range(0, 3) == 0);
      dec_valid = 1'($urandom); imem_rdata = $urandom;
      case ($urandom_range(0, 3))
        0: dec_pc = $urandom & 32'hFFFF_FFFC;
        1: dec_pc = m_fpc - 32'd4;
        default: dec_pc = m_dpc;
      endcase
      jump = ($urandom_range(0, 7) == 0); branch = ($urandom_range(0, 2) == 0);
      lt = 1'($urandom); gt = 1'($urandom); eq = 1'($urandom); src = 1'($urandom); link = 1'($urandom);
      rs_val = $urandom_range(0, 1) ? 32'($urandom_range(0, 6)) - 32'd3 : $urandom;
      rt_val = 32'($urandom_range(0, 6)) - 32'd3;
      imm = 16'($urandom); target = 26'($urandom);
      #1;
      sa = rs_val; sb = src ? rt_val : 0; off = $signed(imm);
      pc4 = dec_pc + 32'd4;
      if (jump) dest = src ? rs_val : ((pc4 & 32'hF000_0000) | {4'd0, target, 2'b00});
      else dest = pc4 + 32'(off * 4);
      e_take = dec_valid && !stall && !reset &&
               (jump || (branch && ((lt && sa < sb) || (gt && sa > sb) || (eq && sa == sb))));
      slot_fetched = e_take && (m_fpc != pc4);
      e_req = !reset && !m_boot && (!m_ifv || !stall) && !slot_fetched;
      if (i > 0) begin
        checks++; if (imem_req !== e_req) begin errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", i, imem_req, e_req); end
        checks++; if (imem_addr !== m_fpc) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", i, imem_addr, m_fpc); end
        checks++; if (br_taken !== e_take) begin errors++; $display("FAIL rnd_taken cyc %0d got %b exp %b", i, br_taken, e_take); end
        checks++; if (link_we !== (dec_valid && !stall && !reset && link)) begin errors++; $display("FAIL rnd_link_we cyc %0d got %b", i, link_we); end
        checks++; if (link_addr !== dec_pc + 32'd8) begin errors++; $display("FAIL rnd_link_addr cyc %0d got %h exp %h", i, link_addr, dec_pc + 32'd8); end
        checks++; if (if_valid !== m_ifv) begin errors++; $display("FAIL rnd_if_valid cyc %0d got %b exp %b", i, if_valid, m_ifv); end
        if (m_ifv) begin
          checks++; if (if_pc !== m_ifp || if_instr !== m_ifi) begin errors++; $display("FAIL rnd_if cyc %0d got %h/%h exp %h/%h", i, if_pc, if_instr, m_ifp, m_ifi); end
        end
      end
      @(posedge clk);
      if (reset) begin
        m_boot = 1'b1; m_fpc = RST_PC; m_ifv = 1'b0; m_ifi = 0; m_ifp = 0; m_redir = 1'b0;
      end else begin
        m_boot = 1'b0;
        fetched = e_req && imem_ack;
        consumed = m_ifv && !stall;
        if (consumed) m_dpc = m_ifp;
        if (slot_fetched) begin
          m_fpc = dest; m_redir = 1'b0;
        end else if (fetched) begin
          m_ifp = m_fpc; m_ifi = imem_rdata;
          m_fpc = e_take ? dest : (m_redir ? m_redir_addr : m_fpc + 32'd4);
          m_redir = 1'b0;
        end else if (e_take) begin
          m_redir = 1'b1; m_redir_addr = dest;
        end
        if (fetched) m_ifv = 1'b1;
        else if (consumed) m_ifv = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_jalr_pending();
    test_bltzal();
    test_stall_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
